// File: rtl/bat_amateur_pkg.sv
// Shared types and constants for the BatAmateur microcoded sequencer.
// Covers the state encoding, opcode classes, jump conditions and fixed register slots.
package bat_amateur_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FA   = 4'd1,
    S_FI   = 4'd2,
    S_DEC  = 4'd3,
    S_OPB  = 4'd4,
    S_ALU  = 4'd5,
    S_MEM1 = 4'd6,
    S_MEM2 = 4'd7,
    S_END  = 4'd8,
    S_HALT = 4'd9
  } state_t;

  localparam logic [3:0] OP_REG   = 4'b0111;
  localparam logic [4:0] ALU_MOV  = 5'b11111;
  localparam logic [4:0] ALU_INC  = 5'b11110;
  localparam logic [4:0] ALU_HALT = 5'b11101;

  localparam logic [1:0] JC_ALWAYS   = 2'b00;
  localparam logic [1:0] JC_FLAG_CLR = 2'b01;
  localparam logic [1:0] JC_FLAG_SET = 2'b10;
  localparam logic [1:0] JC_NEVER    = 2'b11;

  localparam logic [2:0] REG_A = 3'd0;
  localparam logic [2:0] REG_B = 3'd1;

endpackage

// File: rtl/bat_amateur_jump_eval.sv
// Taken/not-taken decision for a jump condition code against the ALU flag.
// Shared by the direct-jump decode and the indirect-jump memory phase.
module bat_amateur_jump_eval
  import bat_amateur_pkg::*;
(
  input  logic [1:0] cond,
  input  logic       flag,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      JC_ALWAYS:   taken = 1'b1;
      JC_FLAG_CLR: taken = ~flag;
      JC_FLAG_SET: taken = flag;
      JC_NEVER:    taken = 1'b0;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/bat_amateur_sequencer.sv
// Named-state control sequencer for the BatAmateur CPU: fetch, decode, ALU and
// memory phases with MEM_READY wait handshake, run/single-step control and HALT.
//
// state  | meaning
// S_IDLE | stopped between instructions, waiting for RUN or STEP
// S_FA   | PC driven onto bus, MAR loads fetch address
// S_FI   | RAM read into IR; PC increments when MEM_READY
// S_DEC  | decode: MOV/INC/HALT, A-operand copy, direct jump, or address load
// S_OPB  | B-operand copy for ALU ops
// S_ALU  | ALU result written to A or B
// S_MEM1 | first memory phase (direct access, indirect pointer, indirect jump)
// S_MEM2 | second memory phase of indirect load/store
// S_END  | instruction retired; continue if RUN
// S_HALT | halted until reset
module bat_amateur_sequencer
  import bat_amateur_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ALU_OP_W = 5,
  parameter int FLAG_BIT = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [7:0]          ALU_REG,
  input  logic [15:0]         INSTR,
  input  logic                MEM_READY,
  input  logic                RUN,
  input  logic                STEP,
  output logic                PC_INC,
  output logic                PC_RW,
  output logic                PC_EN,
  output logic                MAR_LOAD,
  output logic                MAR_EN,
  output logic                RAM_RW,
  output logic                RAM_EN,
  output logic                IR_LOAD,
  output logic                IR_EN,
  output logic [NUM_REGS-1:0] REGS_INC,
  output logic [NUM_REGS-1:0] REGS_RW,
  output logic [NUM_REGS-1:0] REGS_EN,
  output logic                ALU_EN,
  output logic [ALU_OP_W-1:0] ALU_OP,
  output logic                HALTED,
  output logic [3:0]          STATE
);

  state_t state, state_nx;

  logic [ALU_OP_W-1:0] op;
  logic [2:0]          dst_f, src_f, mem_reg;
  logic                is_reg, is_djump, taken;
  logic                unused_alu_bits;

  // Register-file requests collected per state, expanded to per-register vectors below
  logic       rd_ok, wr_ok, inc_ok;
  logic [2:0] rd_sel, wr_sel, inc_sel;

  assign op        = INSTR[7+ALU_OP_W-1:7];
  assign dst_f     = INSTR[5:3];
  assign src_f     = INSTR[2:0];
  assign mem_reg   = INSTR[12] ? REG_B : REG_A;
  assign is_reg    = (INSTR[15:12] == OP_REG);
  assign is_djump  = (INSTR[15:14] == 2'b01) && !is_reg;
  assign unused_alu_bits = ^ALU_REG;
  assign STATE     = state;

  bat_amateur_jump_eval u_jump_eval (
    .cond  (INSTR[13:12]),
    .flag  (ALU_REG[FLAG_BIT]),
    .taken (taken)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    PC_INC   = 1'b0;
    PC_RW    = 1'b1;
    PC_EN    = 1'b0;
    MAR_LOAD = 1'b0;
    MAR_EN   = 1'b1;
    RAM_RW   = 1'b1;
    RAM_EN   = 1'b0;
    IR_LOAD  = 1'b0;
    IR_EN    = 1'b0;
    REGS_INC = '0;
    REGS_RW  = '1;
    REGS_EN  = '0;
    ALU_EN   = 1'b0;
    ALU_OP   = '0;
    HALTED   = 1'b0;
    rd_ok    = 1'b0;
    rd_sel   = REG_A;
    wr_ok    = 1'b0;
    wr_sel   = REG_A;
    inc_ok   = 1'b0;
    inc_sel  = REG_A;

    case (state)
      S_IDLE: if (RUN || STEP) state_nx = S_FA;

      S_FA: begin
        PC_EN    = 1'b1;
        MAR_LOAD = 1'b1;
        state_nx = S_FI;
      end

      S_FI: begin
        RAM_EN  = 1'b1;
        IR_LOAD = 1'b1;
        IR_EN   = 1'b1;
        if (MEM_READY) begin
          PC_INC   = 1'b1;
          PC_RW    = 1'b0;
          state_nx = S_DEC;
        end
      end

      S_DEC: begin
        if (is_reg) begin
          if (op == ALU_MOV) begin
            rd_ok    = 1'b1;
            rd_sel   = src_f;
            wr_ok    = 1'b1;
            wr_sel   = dst_f;
            state_nx = S_END;
          end else if (op == ALU_INC) begin
            inc_ok   = 1'b1;
            inc_sel  = dst_f;
            state_nx = S_END;
          end else if (op == ALU_HALT) begin
            state_nx = S_HALT;
          end else begin
            if (dst_f != REG_A) begin
              rd_ok  = 1'b1;
              rd_sel = dst_f;
              wr_ok  = 1'b1;
              wr_sel = REG_A;
            end
            state_nx = S_OPB;
          end
        end else if (is_djump) begin
          if (taken) begin
            IR_EN = 1'b1;
            PC_EN = 1'b1;
            PC_RW = 1'b0;
          end
          state_nx = S_END;
        end else begin
          IR_EN    = 1'b1;
          MAR_LOAD = 1'b1;
          state_nx = S_MEM1;
        end
      end

      S_OPB: begin
        if (src_f != REG_B) begin
          rd_ok  = 1'b1;
          rd_sel = src_f;
          wr_ok  = 1'b1;
          wr_sel = REG_B;
        end
        state_nx = S_ALU;
      end

      S_ALU: begin
        ALU_EN   = 1'b1;
        ALU_OP   = op;
        wr_ok    = 1'b1;
        wr_sel   = INSTR[6] ? REG_A : REG_B;
        state_nx = S_END;
      end

      S_MEM1: begin
        if (INSTR[15] && INSTR[14]) begin
          if (taken) begin
            RAM_EN = 1'b1;
            PC_EN  = 1'b1;
            PC_RW  = 1'b0;
          end
          if (MEM_READY) state_nx = S_END;
        end else if (INSTR[15]) begin
          RAM_EN   = 1'b1;
          MAR_LOAD = 1'b1;
          if (MEM_READY) state_nx = S_MEM2;
        end else begin
          RAM_EN = 1'b1;
          if (INSTR[13]) begin
            RAM_RW = 1'b0;
            rd_ok  = 1'b1;
            rd_sel = mem_reg;
          end else begin
            wr_ok  = 1'b1;
            wr_sel = mem_reg;
          end
          if (MEM_READY) state_nx = S_END;
        end
      end

      S_MEM2: begin
        RAM_EN = 1'b1;
        if (INSTR[13]) begin
          RAM_RW = 1'b0;
          rd_ok  = 1'b1;
          rd_sel = mem_reg;
        end else begin
          wr_ok  = 1'b1;
          wr_sel = mem_reg;
        end
        if (MEM_READY) state_nx = S_END;
      end

      S_END: state_nx = RUN ? S_FA : S_IDLE;

      S_HALT: HALTED = 1'b1;

      default: state_nx = S_IDLE;
    endcase

    // Selects at or above NUM_REGS never match, so they produce no strobe
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_ok && rd_sel == i[2:0]) REGS_EN[i] = 1'b1;
      if (wr_ok && wr_sel == i[2:0]) begin
        REGS_EN[i] = 1'b1;
        REGS_RW[i] = 1'b0;
      end
      if (inc_ok && inc_sel == i[2:0]) begin
        REGS_INC[i] = 1'b1;
        REGS_RW[i]  = 1'b0;
      end
    end
  end

endmodule
